ex_mem_buffer: RTL

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

---
 rtl/ex_mem_buffer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: two-entry FIFO skid buffer between the EX and MEM pipeline stages.
//
// Each entry carries the ALU result, store data, destination register index and the
// regWr/memRd/memWr controls (plus the ALU flags when EX_MEM_FLAGS_EN is defined).
// inReady and outValid depend only on registered occupancy, so neither handshake side
// sees a combinational path from the other.
//
// Optional feature macro: EX_MEM_FLAGS_EN
//   defined   -> zALU/oALU/cALU/nALU are stored per entry and presented on zOut..nOut
//   undefined -> no flag storage; zOut..nOut are tied to 0
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset_n      in   synchronous active-low reset, dominates flush and handshakes
//   flush        in   synchronous discard of all buffered entries
//   inValid      in   upstream entry valid
//   inReady      out  buffer can take an entry (count != 2)
//   busALU       in   ALU result [DATA_W]
//   zALU..nALU   in   ALU zero/overflow/carry/negative flags
//   busStore     in   store data [DATA_W]
//   rdIn         in   destination register index [REG_W]
//   regWrIn      in   register write enable
//   memRdIn      in   memory read enable
//   memWrIn      in   memory write enable
//   outValid     out  head entry valid (count != 0)
//   outReady     in   downstream accepts head entry
//   busOut..memWrOut out  head entry fields, all 0 when the buffer is empty
//   count        out  number of buffered entries (0..2)
module ex_mem_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,

    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] busALU,
    input  logic              zALU,
    input  logic              oALU,
    input  logic              cALU,
    input  logic              nALU,
    input  logic [DATA_W-1:0] busStore,
    input  logic [REG_W-1:0]  rdIn,
    input  logic              regWrIn,
    input  logic              memRdIn,
    input  logic              memWrIn,

    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] busOut,
    output logic              zOut,
    output logic              oOut,
    output logic              cOut,
    output logic              nOut,
    output logic [DATA_W-1:0] busStoreOut,
    output logic [REG_W-1:0]  rdOut,
    output logic              regWrOut,
    output logic              memRdOut,
    output logic              memWrOut,

    output logic [1:0]        count
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] store;
        logic [REG_W-1:0]  rd;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
`ifdef EX_MEM_FLAGS_EN
        logic              z;
        logic              o;
        logic              c;
        logic              n;
`endif
    } entry_t;

    // slot0 is always the head; slot1 holds the second entry when count == 2.
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;

    entry_t     in_entry;
    entry_t     head;
    logic       accept;
    logic       emit;
    logic       write_head;

    always_comb begin
        in_entry        = '0;
        in_entry.alu    = busALU;
        in_entry.store  = busStore;
        in_entry.rd     = rdIn;
        in_entry.reg_wr = regWrIn;
        in_entry.mem_rd = memRdIn;
        in_entry.mem_wr = memWrIn;
`ifdef EX_MEM_FLAGS_EN
        in_entry.z      = zALU;
        in_entry.o      = oALU;
        in_entry.c      = cALU;
        in_entry.n      = nALU;
`endif
    end

    assign inReady  = (count_q != 2'd2);
    assign outValid = (count_q != 2'd0);
    assign accept   = inValid && inReady;
    assign emit     = outValid && outReady;

    // The new entry lands at the head if the buffer is, or is about to become, empty.
    assign write_head = (count_q == 2'd0) || ((count_q == 2'd1) && emit);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = 2'd0;
        end else begin
            if (emit) begin
                slot0_d = slot1_q;
                slot1_d = '0;
            end
            if (accept) begin
                if (write_head) begin
                    slot0_d = in_entry;
                end else begin
                    slot1_d = in_entry;
                end
            end
            count_d = count_q + {1'b0, accept} - {1'b0, emit};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    // Outputs are forced to 0 whenever nothing is valid.
    assign head        = outValid ? slot0_q : '0;
    assign busOut      = head.alu;
    assign busStoreOut = head.store;
    assign rdOut       = head.rd;
    assign regWrOut    = head.reg_wr;
    assign memRdOut    = head.mem_rd;
    assign memWrOut    = head.mem_wr;
    assign count       = count_q;

`ifdef EX_MEM_FLAGS_EN
    assign zOut = head.z;
    assign oOut = head.o;
    assign cOut = head.c;
    assign nOut = head.n;
`else
    logic unused_flags;
    assign unused_flags = ^{zALU, oALU, cALU, nALU};
    assign zOut = 1'b0;
    assign oOut = 1'b0;
    assign cOut = 1'b0;
    assign nOut = 1'b0;
`endif

endmodule
